// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

    // Clear-engine state: CLEAR zeroes one entry per cycle, RUN serves reads and writes.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;

    // Fixed-width view used by the priority matcher.
    // Supports up to 16 write ports with addresses up to 16 bits wide.
    localparam int MATCH_PORTS = 16;
    localparam int MATCH_AW    = 16;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } match_t;

    // Finds the highest-numbered enabled port whose address equals addr.
    // The loop ascends, so later (higher) ports overwrite earlier hits.
    function automatic match_t hi_prio_match(
        input logic [MATCH_AW-1:0]             addr,
        input logic [MATCH_PORTS-1:0]          en,
        input logic [MATCH_PORTS*MATCH_AW-1:0] addrs
    );
        match_t m;
        m.hit = 1'b0;
        m.idx = '0;
        for (int i = 0; i < MATCH_PORTS; i++) begin
            if (en[i] && (addrs[i*MATCH_AW +: MATCH_AW] == addr)) begin
                m.hit = 1'b1;
                m.idx = 4'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear engine: walks every entry once, then raises Ready.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr,
    output logic              Ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_clr_idx, w_clr_idx_next;
    logic              r_ready, w_ready_next;

    // State, index and Ready registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_idx <= w_clr_idx_next;
            r_ready   <= w_ready_next;
        end
    end

    // Advance one entry per cycle; the last entry hands over to RUN.
    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_ready_next   = r_ready;
        case (r_state)
            CLEAR: begin
                w_clr_idx_next = r_clr_idx + 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_next   = RUN;
                    w_ready_next   = 1'b1;
                    w_clr_idx_next = '0;
                end
            end
            default: ;
        endcase
    end

    assign clear_we   = (r_state == CLEAR);
    assign clear_addr = r_clr_idx;
    assign Ready      = r_ready;

endmodule

// File: rtl/multiport_register_file.sv
// N-read / M-write register file with write priority, optional bypass and a zero register.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] Rd_Addr,
    output logic [NUM_RD*DATA_W-1:0] Rd_Data,
    input  logic [NUM_WR-1:0]        Wr_En,
    input  logic [NUM_WR*ADDR_W-1:0] Wr_Addr,
    input  logic [NUM_WR*DATA_W-1:0] Wr_Data,
    output logic                     Ready,
    output logic                     Wr_Conflict
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic              w_ready;
    logic              w_clear_we;
    logic [ADDR_W-1:0] w_clear_addr;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .clear_we   (w_clear_we),
        .clear_addr (w_clear_addr),
        .Ready      (w_ready)
    );

    assign Ready = w_ready;

    // Unpack write ports and qualify each into an "effective" write.
    logic [ADDR_W-1:0] w_wr_addr [NUM_WR];
    logic [DATA_W-1:0] w_wr_data [NUM_WR];
    logic [NUM_WR-1:0] w_wr_eff;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign w_wr_addr[gi] = Wr_Addr[gi*ADDR_W +: ADDR_W];
            assign w_wr_data[gi] = Wr_Data[gi*DATA_W +: DATA_W];
            assign w_wr_eff[gi]  = Wr_En[gi] && w_ready && !reset
                                 && ({1'b0, w_wr_addr[gi]} < DEPTH_LIM)
                                 && !((ZERO_REG != 0) && (w_wr_addr[gi] == '0));
        end
    endgenerate

    // Pad write enables/addresses to the fixed width the priority matcher expects.
    logic [MATCH_PORTS-1:0]          w_eff_pad;
    logic [MATCH_PORTS*MATCH_AW-1:0] w_addr_pad;

    always_comb begin
        w_eff_pad  = '0;
        w_addr_pad = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            w_eff_pad[i]                     = w_wr_eff[i];
            w_addr_pad[i*MATCH_AW +: MATCH_AW] = MATCH_AW'(w_wr_addr[i]);
        end
    end

    // Storage: one register per entry, each merging clear and the winning write port.
    logic [DATA_W-1:0] w_mem [DEPTH];

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [ADDR_W-1:0] E_ADDR = ADDR_W'(gi);
            logic              w_we;
            logic [DATA_W-1:0] w_wd;
            logic [DATA_W-1:0] r_entry;

            // Ascending scan so the highest-numbered matching port supplies the data.
            always_comb begin
                w_we = 1'b0;
                w_wd = '0;
                if (!reset && w_clear_we && (w_clear_addr == E_ADDR)) begin
                    w_we = 1'b1;
                end
                for (int i = 0; i < NUM_WR; i++) begin
                    if (w_wr_eff[i] && (w_wr_addr[i] == E_ADDR)) begin
                        w_we = 1'b1;
                        w_wd = w_wr_data[i];
                    end
                end
            end

            // Entry update; contents are left alone by reset and only zeroed by the clear sweep.
            always_ff @(posedge clk) begin
                if (w_we) begin
                    r_entry <= w_wd;
                end
            end

            assign w_mem[gi] = r_entry;
        end
    endgenerate

    // Read ports: range/zero/Ready masking, then optional same-cycle forwarding.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_valid;
            match_t            w_match;
            logic [DATA_W-1:0] w_byp;

            assign w_addr  = Rd_Addr[gi*ADDR_W +: ADDR_W];
            assign w_valid = w_ready
                           && ({1'b0, w_addr} < DEPTH_LIM)
                           && !((ZERO_REG != 0) && (w_addr == '0));
            assign w_match = hi_prio_match(MATCH_AW'(w_addr), w_eff_pad, w_addr_pad);

            // Select the winning port's write data for forwarding.
            always_comb begin
                w_byp = '0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_match.idx == 4'(j)) begin
                        w_byp = w_wr_data[j];
                    end
                end
            end

            assign Rd_Data[gi*DATA_W +: DATA_W] =
                !w_valid                         ? '0    :
                ((BYPASS != 0) && w_match.hit)   ? w_byp :
                                                   w_mem[w_addr];
        end
    endgenerate

    // Any two effective writes to the same address this cycle.
    logic w_conflict;

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (w_wr_eff[i] && w_wr_eff[j] && (w_wr_addr[i] == w_wr_addr[j])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Registered one-cycle conflict pulse.
    logic r_conflict;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_conflict;
        end
    end

    assign Wr_Conflict = r_conflict;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: default instance, a no-bypass instance and a 24-deep 6R/3W instance.
module tb_multiport_register_file;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Default and no-bypass instances share their stimulus.
    logic [19:0]  rd_addr;
    logic [127:0] rd_data_a, rd_data_nb;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         ready_a, conf_a, ready_nb, conf_nb;

    // Geometry instance.
    logic [29:0]  g_rd_addr;
    logic [191:0] g_rd_data;
    logic [2:0]   g_wr_en;
    logic [14:0]  g_wr_addr;
    logic [95:0]  g_wr_data;
    logic         g_ready, g_conf;

    int n_tests = 0;
    int n_fail  = 0;

    multiport_register_file dut_a (
        .clk(clk), .reset(reset),
        .Rd_Addr(rd_addr), .Rd_Data(rd_data_a),
        .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
        .Ready(ready_a), .Wr_Conflict(conf_a)
    );

    multiport_register_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .Rd_Addr(rd_addr), .Rd_Data(rd_data_nb),
        .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
        .Ready(ready_nb), .Wr_Conflict(conf_nb)
    );

    multiport_register_file #(.DEPTH(24), .NUM_RD(6), .NUM_WR(3)) dut_g (
        .clk(clk), .reset(reset),
        .Rd_Addr(g_rd_addr), .Rd_Data(g_rd_data),
        .Wr_En(g_wr_en), .Wr_Addr(g_wr_addr), .Wr_Data(g_wr_data),
        .Ready(g_ready), .Wr_Conflict(g_conf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        rd_addr[k*5 +: 5] = a;
    endtask

    task automatic wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]           = en;
        wr_addr[p*5 +: 5]  = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic g_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        g_wr_en[p]            = en;
        g_wr_addr[p*5 +: 5]   = a;
        g_wr_data[p*32 +: 32] = d;
    endtask

    function automatic logic [31:0] rd_a(input int k);
        return rd_data_a[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_nb(input int k);
        return rd_data_nb[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_g(input int k);
        return g_rd_data[k*32 +: 32];
    endfunction

    initial begin
        reset     = 1'b1;
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        g_rd_addr = '0;
        g_wr_en   = '0;
        g_wr_addr = '0;
        g_wr_data = '0;

        // Reset held for three cycles.
        repeat (3) step();
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_conf", 32'(conf_a), 32'd0);
        chk("rst_ready_g", 32'(g_ready), 32'd0);

        // Clear sweep: Ready rises at edge DEPTH; writes during clear are dropped.
        set_rd(0, 5'd31); set_rd(1, 5'd17); set_rd(2, 5'd5); set_rd(3, 5'd1);
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            if (e == 20) wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
            if (e == 32) wr(0, 1'b0, 5'd0, 32'h0);
            step();
            chk($sformatf("clr_ready_e%0d", e), 32'(ready_a), (e == 32) ? 32'd1 : 32'd0);
            if (e == 10 || e == 25) begin
                for (int k = 0; k < 4; k++) chk($sformatf("clr_rd%0d_e%0d", k, e), rd_a(k), 32'h0);
            end
            if (e == 23) chk("g_ready_e23", 32'(g_ready), 32'd0);
            if (e == 24) chk("g_ready_e24", 32'(g_ready), 32'd1);
        end
        chk("clr_conf", 32'(conf_a), 32'd0);
        chk("nb_ready", 32'(ready_nb), 32'd1);

        // Every address reads zero after clear (r5 included).
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) set_rd(k, 5'(b*4 + k));
            #1;
            for (int k = 0; k < 4; k++) chk($sformatf("postclr_r%0d", b*4 + k), rd_a(k), 32'h0);
            step();
        end

        // Basic write: same-cycle forward, then stored value on all ports.
        for (int k = 0; k < 4; k++) set_rd(k, 5'd3);
        wr(0, 1'b1, 5'd3, 32'h12345678);
        #1;
        chk("wr3_bypass", rd_a(1), 32'h12345678);
        step();
        wr(0, 1'b0, 5'd0, 32'h0);
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("wr3_rd%0d", k), rd_a(k), 32'h12345678);
        step();

        // Write to r0 is ignored and never forwarded.
        for (int k = 0; k < 4; k++) set_rd(k, 5'd0);
        wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        chk("r0_bypass", rd_a(0), 32'h0);
        step();
        wr(0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("r0_rd", rd_a(2), 32'h0);
        chk("r0_conf", 32'(conf_a), 32'd0);
        step();

        // Collision on r7: port1 wins, conflict pulses for one cycle.
        for (int k = 0; k < 4; k++) set_rd(k, 5'd7);
        wr(0, 1'b1, 5'd7, 32'h1111);
        wr(1, 1'b1, 5'd7, 32'h2222);
        #1;
        chk("col_bypass", rd_a(0), 32'h2222);
        chk("col_conf_pre", 32'(conf_a), 32'd0);
        step();
        wr(0, 1'b0, 5'd0, 32'h0);
        wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        chk("col_conf", 32'(conf_a), 32'd1);
        chk("col_r7", rd_a(3), 32'h2222);
        chk("col_r7_nb", rd_nb(3), 32'h2222);
        step();
        chk("col_conf_drop", 32'(conf_a), 32'd0);

        // Both ports to r0: not effective, so no conflict.
        wr(0, 1'b1, 5'd0, 32'hAAAA);
        wr(1, 1'b1, 5'd0, 32'hBBBB);
        step();
        wr(0, 1'b0, 5'd0, 32'h0);
        wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        chk("r0col_conf", 32'(conf_a), 32'd0);
        step();

        // Bypass vs no bypass on r9 (old value 0x5555).
        wr(0, 1'b1, 5'd9, 32'h5555);
        step();
        wr(0, 1'b0, 5'd0, 32'h0);
        set_rd(2, 5'd9);
        wr(1, 1'b1, 5'd9, 32'hABCD);
        #1;
        chk("byp_a", rd_a(2), 32'hABCD);
        chk("byp_nb_old", rd_nb(2), 32'h5555);
        step();
        wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        chk("byp_nb_new", rd_nb(2), 32'hABCD);
        chk("byp_a_new", rd_a(2), 32'hABCD);
        step();

        // Load r1..r31 with their index, two per cycle.
        for (int i = 1; i < 32; i += 2) begin
            wr(0, 1'b1, 5'(i), 32'(i));
            if (i + 1 < 32) wr(1, 1'b1, 5'(i + 1), 32'(i + 1));
            else            wr(1, 1'b0, 5'd0, 32'h0);
            step();
        end
        wr(0, 1'b0, 5'd0, 32'h0);
        wr(1, 1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd1); set_rd(1, 5'd16); set_rd(2, 5'd17); set_rd(3, 5'd31);
        #1;
        chk("load_r1", rd_a(0), 32'd1);
        chk("load_r16", rd_a(1), 32'd16);
        chk("load_r17", rd_a(2), 32'd17);
        chk("load_r31", rd_a(3), 32'd31);
        step();

        // Mid-run reset: Ready drops, reads zero, clear redone in 32 edges.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mrst_ready", 32'(ready_a), 32'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("mrst_rd%0d", k), rd_a(k), 32'h0);
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 31) chk("mrst_ready_e31", 32'(ready_a), 32'd0);
            if (e == 32) chk("mrst_ready_e32", 32'(ready_a), 32'd1);
        end
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) set_rd(k, 5'(b*4 + k));
            #1;
            for (int k = 0; k < 4; k++) chk($sformatf("mrst_r%0d", b*4 + k), rd_a(k), 32'h0);
            step();
        end

        // Geometry: out-of-range write/read on the 24-deep instance.
        chk("g_ready", 32'(g_ready), 32'd1);
        g_rd_addr[0*5 +: 5] = 5'd30;
        g_rd_addr[1*5 +: 5] = 5'd6;
        g_wr(0, 1'b1, 5'd30, 32'h30303030);
        #1;
        chk("g_oor_bypass", rd_g(0), 32'h0);
        step();
        g_wr(0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("g_oor_rd30", rd_g(0), 32'h0);
        chk("g_oor_rd6", rd_g(1), 32'h0);
        chk("g_oor_conf", 32'(g_conf), 32'd0);
        step();

        // Three ports write r4: port2 wins.
        g_rd_addr[5*5 +: 5] = 5'd4;
        g_wr(0, 1'b1, 5'd4, 32'h44440000);
        g_wr(1, 1'b1, 5'd4, 32'h44441111);
        g_wr(2, 1'b1, 5'd4, 32'h44442222);
        #1;
        chk("g_col_bypass", rd_g(5), 32'h44442222);
        step();
        for (int p = 0; p < 3; p++) g_wr(p, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 6; k++) g_rd_addr[k*5 +: 5] = 5'd4;
        #1;
        for (int k = 0; k < 6; k++) chk($sformatf("g_col_rd%0d", k), rd_g(k), 32'h44442222);
        chk("g_col_conf", 32'(g_conf), 32'd1);
        step();
        chk("g_col_conf_drop", 32'(g_conf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
